// File: rtl/posit_addsub_sched.sv
// posit_addsub_sched
// Round-robin front end for one shared, fixed-latency posit add/subtract
// datapath. A request is issued only when its result is sure to find a free
// slot in the result FIFO, because the datapath has no backpressure. Results
// come back on one valid/ready channel, in issue order, tagged with the
// requester index.
module posit_addsub_sched #(
  parameter int N     = 32,
  parameter int ES    = 2,
  parameter int NREQ  = 4,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*N-1:0]         req_a,
  input  logic [NREQ*N-1:0]         req_b,
  input  logic [NREQ-1:0]           req_sub,
  output logic                      dp_valid,
  output logic [N-1:0]              dp_a,
  output logic [N-1:0]              dp_b,
  output logic                      dp_sub,
  input  logic [N-1:0]              dp_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [N-1:0]              rsp_data,
  output logic [$clog2(NREQ)-1:0]   rsp_id
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int IW  = $clog2(LAT + 2);

  // arbitration
  logic [IDW-1:0] rr_ptr;
  logic           issue_ok;
  logic           grant_any;
  logic [IDW-1:0] grant_id;

  // tag pipe: stage 0 lines up with dp_valid, stage LAT with dp_result
  logic [LAT:0]   tag_v;
  logic [IDW-1:0] tag_id [0:LAT];

  // result FIFO and credit tracking
  logic           push;
  logic           pop;
  logic [IDW-1:0] push_id;
  logic [IW-1:0]  inflight_count;
  logic [CW-1:0]  fifo_count;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [N-1:0]   mem_data [0:DEPTH-1];
  logic [IDW-1:0] mem_id   [0:DEPTH-1];

  // Requester index k places after base, wrapping at NREQ (NREQ need not be
  // a power of two).
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base,
                                              input int             k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // FIFO pointer increment with wrap at DEPTH.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // An issue is allowed only when every op already launched plus this one
  // can land in the FIFO. A pop this cycle is deliberately not counted.
  assign issue_ok = (int'(fifo_count) + int'(inflight_count)) < DEPTH;

  // Round-robin grant: search from rr_ptr upward, lowest distance wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    req_ready = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[rr_index(rr_ptr, k)]) begin
        grant_any = issue_ok;
        grant_id  = rr_index(rr_ptr, k);
      end
    end
    if (grant_any) req_ready[grant_id] = 1'b1;
  end

  // Pointer moves just past the requester that was served; holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= rr_index(grant_id, 1);
    end
  end

  // Operand register: operands are sampled only on the handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dp_a   <= '0;
      dp_b   <= '0;
      dp_sub <= 1'b0;
    end else if (grant_any) begin
      dp_a   <= req_a[int'(grant_id)*N +: N];
      dp_b   <= req_b[int'(grant_id)*N +: N];
      dp_sub <= req_sub[grant_id];
    end
  end

  assign dp_valid = tag_v[0];

  // Tag shift register follows each op through the datapath latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int i = 0; i <= LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= grant_any;
      tag_id[0] <= grant_id;
      for (int i = 1; i <= LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign push    = tag_v[LAT];
  assign push_id = tag_id[LAT];
  assign pop     = rsp_valid & rsp_ready;

  // In-flight count: issued but not yet written into the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_count <= '0;
    end else if (grant_any && !push) begin
      inflight_count <= inflight_count + 1'b1;
    end else if (!grant_any && push) begin
      inflight_count <= inflight_count - 1'b1;
    end
  end

  // FIFO pointers and occupancy; a push into a full FIFO means the credit
  // accounting is broken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (!push && pop) begin
        fifo_count <= fifo_count - 1'b1;
      end
      assert (!(push && (fifo_count == CW'(DEPTH))));
      assert ((ES >= 0) && (DEPTH >= LAT + 1));
    end
  end

  // FIFO storage; contents are never observed while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= dp_result;
      mem_id[wr_ptr]   <= push_id;
    end
  end

  assign rsp_valid = (fifo_count != '0);
  assign rsp_data  = rsp_valid ? mem_data[rd_ptr] : '0;
  assign rsp_id    = rsp_valid ? mem_id[rd_ptr]   : '0;

endmodule

// File: tb/tb_posit_addsub_sched.sv
// Testbench for posit_addsub_sched: table vectors, directed corner sequences
// and random traffic, all checked against a queue-based reference model.
module tb_posit_addsub_sched;

  localparam int N     = 32;
  localparam int ES    = 2;
  localparam int NREQ  = 4;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int IDW   = $clog2(NREQ);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*N-1:0]   req_a = '0;
  logic [NREQ*N-1:0]   req_b = '0;
  logic [NREQ-1:0]     req_sub = '0;
  logic                dp_valid;
  logic [N-1:0]        dp_a;
  logic [N-1:0]        dp_b;
  logic                dp_sub;
  logic [N-1:0]        dp_result = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [N-1:0]        rsp_data;
  logic [IDW-1:0]      rsp_id;

  always #5 clk = ~clk;

  posit_addsub_sched #(.N(N), .ES(ES), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .dp_valid(dp_valid), .dp_a(dp_a), .dp_b(dp_b), .dp_sub(dp_sub),
    .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: ops waiting for their result cycle, then results queued
  // for the consumer. Entry due = cycle in which the datapath presents it.
  typedef struct packed {
    logic [31:0]  id;
    logic [N-1:0] res;
    logic [31:0]  due;
  } op_t;
  op_t          infl_q[$];
  op_t          fifo_q[$];
  int           m_rr  = 0;
  logic         m_dpv = 1'b0;
  logic [N-1:0] m_a   = '0;
  logic [N-1:0] m_b   = '0;
  logic         m_sub = 1'b0;

  // Stand-in datapath: remembers what was issued each cycle and answers LAT later.
  logic         h_v [8];
  logic [N-1:0] h_r [8];

  logic [NREQ-1:0] obs_ready;
  logic            obs_dpv, obs_dpsub, obs_rspv;
  logic [N-1:0]    obs_dpa, obs_dpb, obs_data;
  logic [IDW-1:0]  obs_id;

  typedef struct packed {
    logic [31:0]  id;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic [N-1:0] exp;
  } vec_t;
  vec_t vecs [6];

  function automatic logic [N-1:0] dp_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic s);
    return s ? a - b : a + b;
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] v);
    if (fifo_q.size() + infl_q.size() >= DEPTH) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (v[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic s);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_sub[i]      = s;
  endtask

  task automatic rand_ops();
    req_a   = {$urandom, $urandom, $urandom, $urandom};
    req_b   = {$urandom, $urandom, $urandom, $urandom};
    req_sub = 4'($urandom_range(0, 15));
  endtask

  // One clock cycle: drive at the falling edge, compare, advance the model.
  task automatic step(input logic [NREQ-1:0] v, input logic rr);
    int              g;
    logic [NREQ-1:0] exp_ready;
    logic [N-1:0]    a_g, b_g;
    logic            s_g;
    req_valid = v;
    rsp_ready = rr;
    if (cyc >= LAT && h_v[(cyc - LAT) % 8]) dp_result = h_r[(cyc - LAT) % 8];
    else dp_result = $urandom;
    #1;
    g = model_grant(v);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    obs_ready = req_ready;  obs_dpv = dp_valid;  obs_dpa = dp_a;  obs_dpb = dp_b;
    obs_dpsub = dp_sub;     obs_rspv = rsp_valid; obs_data = rsp_data; obs_id = rsp_id;
    check("req_ready", obs_ready, exp_ready);
    check("dp_valid", obs_dpv, m_dpv);
    if (m_dpv) begin
      check("dp_a", obs_dpa, m_a);
      check("dp_b", obs_dpb, m_b);
      check("dp_sub", obs_dpsub, m_sub);
    end
    check("rsp_valid", obs_rspv, fifo_q.size() != 0);
    if (fifo_q.size() != 0) begin
      check("rsp_data", obs_data, fifo_q[0].res);
      check("rsp_id", obs_id, fifo_q[0].id);
    end
    h_v[cyc % 8] = dp_valid;
    h_r[cyc % 8] = dp_fn(dp_a, dp_b, dp_sub);
    a_g = '0; b_g = '0; s_g = 1'b0;
    if (g >= 0) begin
      a_g = req_a[g*N +: N];
      b_g = req_b[g*N +: N];
      s_g = req_sub[g];
    end
    @(posedge clk);
    if (fifo_q.size() != 0 && rr) void'(fifo_q.pop_front());
    if (infl_q.size() != 0 && infl_q[0].due == 32'(cyc)) begin
      fifo_q.push_back(infl_q[0]);
      void'(infl_q.pop_front());
    end
    if (g >= 0) begin
      infl_q.push_back('{id: 32'(g), res: dp_fn(a_g, b_g, s_g), due: 32'(cyc + 1 + LAT)});
      m_rr  = (g + 1) % NREQ;
      m_dpv = 1'b1;
      m_a   = a_g;
      m_b   = b_g;
      m_sub = s_g;
    end else begin
      m_dpv = 1'b0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_dp_valid", dp_valid, 0);
    check("rst_dp_a", dp_a, 0);
    check("rst_dp_b", dp_b, 0);
    check("rst_dp_sub", dp_sub, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    infl_q.delete();
    fifo_q.delete();
    m_rr  = 0;
    m_dpv = 1'b0;
    for (int i = 0; i < 8; i++) h_v[i] = 1'b0;
    cyc++;
  endtask

  initial begin
    int exp_g, exp_id, grants;

    vecs[0] = '{id: 32'd0, a: 32'h48000000, b: 32'h40000000, sub: 1'b0, exp: 32'h88000000};
    vecs[1] = '{id: 32'd0, a: 32'h48000000, b: 32'h40000000, sub: 1'b1, exp: 32'h08000000};
    vecs[2] = '{id: 32'd1, a: 32'h7FFFFFFF, b: 32'h00000001, sub: 1'b0, exp: 32'h80000000};
    vecs[3] = '{id: 32'd2, a: 32'h00000000, b: 32'h00000001, sub: 1'b1, exp: 32'hFFFFFFFF};
    vecs[4] = '{id: 32'd3, a: 32'h12345678, b: 32'h11111111, sub: 1'b0, exp: 32'h23456789};
    vecs[5] = '{id: 32'd3, a: 32'h40000000, b: 32'h48000000, sub: 1'b1, exp: 32'hF8000000};
    for (int i = 0; i < 8; i++) begin
      h_v[i] = 1'b0;
      h_r[i] = '0;
    end

    @(negedge clk);
    do_reset();

    // Single operations: grant, operand register, LAT+1 response latency.
    for (int i = 0; i < 6; i++) begin
      set_ops(int'(vecs[i].id), vecs[i].a, vecs[i].b, vecs[i].sub);
      step(NREQ'(1) << vecs[i].id, 1'b0);
      check("vec_grant", obs_ready, NREQ'(1) << vecs[i].id);
      step('0, 1'b0);
      check("vec_dp_valid", obs_dpv, 1);
      check("vec_dp_a", obs_dpa, vecs[i].a);
      check("vec_dp_b", obs_dpb, vecs[i].b);
      check("vec_dp_sub", obs_dpsub, vecs[i].sub);
      step('0, 1'b0);
      step('0, 1'b0);
      step('0, 1'b0);
      check("vec_rsp_early", obs_rspv, 0);
      step('0, 1'b1);
      check("vec_rsp_valid", obs_rspv, 1);
      check("vec_rsp_data", obs_data, vecs[i].exp);
      check("vec_rsp_id", obs_id, vecs[i].id);
    end

    // All requesters busy: grant order and response order rotate 0..3.
    do_reset();
    exp_g  = 0;
    exp_id = 0;
    repeat (24) begin
      rand_ops();
      step('1, 1'b1);
      if (obs_ready != '0) begin
        check("rr_order", obs_ready, NREQ'(1) << exp_g);
        exp_g = (exp_g + 1) % NREQ;
      end
      if (obs_rspv) begin
        check("rsp_id_order", obs_id, exp_id);
        exp_id = (exp_id + 1) % NREQ;
      end
    end

    // Consumer stalled: exactly DEPTH issues, then one more after one pop.
    do_reset();
    grants = 0;
    repeat (10) begin
      rand_ops();
      step('1, 1'b0);
      if (obs_ready != '0) grants++;
    end
    check("credit_issues", grants, DEPTH);
    check("credit_blocked", obs_ready, 0);
    step('1, 1'b1);
    check("credit_pop_same_cycle", obs_ready, 0);
    step('1, 1'b0);
    check("credit_after_pop", obs_ready != '0, 1);
    step('1, 1'b0);
    check("credit_full_again", obs_ready, 0);

    // Pointer at 2 with only req0/req3 valid.
    do_reset();
    step(4'b0010, 1'b1);
    check("rr_setup", obs_ready, 4'b0010);
    step(4'b1001, 1'b1);
    check("rr_wrap_1", obs_ready, 4'b1000);
    step(4'b1001, 1'b1);
    check("rr_wrap_2", obs_ready, 4'b0001);
    step(4'b1001, 1'b1);
    check("rr_wrap_3", obs_ready, 4'b1000);
    repeat (6) step('0, 1'b1);

    // Reset with two ops in flight and one result waiting.
    do_reset();
    set_ops(0, 32'h48000000, 32'h40000000, 1'b0);
    step(4'b0001, 1'b0);
    step('0, 1'b0);
    step('0, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    step('0, 1'b0);
    check("pre_reset_rsp", obs_rspv, 1);
    do_reset();
    repeat (8) begin
      step('0, 1'b1);
      check("post_reset_no_rsp", obs_rspv, 0);
    end

    // Subtract operands pass through; push+pop at one entry keeps one entry.
    set_ops(1, 32'h48000000, 32'h40000000, 1'b1);
    set_ops(2, 32'h48000000, 32'h40000000, 1'b1);
    step(4'b0010, 1'b0);
    step(4'b0100, 1'b0);
    check("sub_dp_sub", obs_dpsub, 1);
    check("sub_dp_a", obs_dpa, 32'h48000000);
    check("sub_dp_b", obs_dpb, 32'h40000000);
    step('0, 1'b0);
    step('0, 1'b0);
    step('0, 1'b0);
    step('0, 1'b1);
    check("pp_first_id", obs_id, 1);
    check("pp_first_data", obs_data, 32'h08000000);
    step('0, 1'b0);
    check("pp_count_kept", obs_rspv, 1);
    check("pp_second_id", obs_id, 2);
    step('0, 1'b1);
    step('0, 1'b0);
    check("pp_drained", obs_rspv, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      rand_ops();
      step(NREQ'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    end
    repeat (10) step('0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
